stoch_signed_stream_decoder: RTL and testbench

//  Converts NUM_STREAMS signed stochastic bitstream pairs (x_p/x_m) to fixed-point binary.

---
 rtl/stoch_signed_stream_decoder.sv | 93 +++++++++
 tb/tb_stoch_signed_stream_decoder.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/stoch_signed_stream_decoder.sv
// Signed stochastic bitstream decoder: per-lane up/down count of x_p - x_m over a
// 2^WINDOW_LOG2-sample window, emitted as one packed word through a single-entry buffer.
module stoch_signed_stream_decoder #(
  parameter int NUM_STREAMS = 16,
  parameter int WINDOW_LOG2 = 8,
  localparam int ACC_WIDTH  = WINDOW_LOG2 + 2
) (
  input  logic                               CLK,
  input  logic                               RST,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [NUM_STREAMS-1:0]             x_p,
  input  logic [NUM_STREAMS-1:0]             x_m,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [NUM_STREAMS*ACC_WIDTH-1:0]   out_data,
  output logic [WINDOW_LOG2-1:0]             win_count
);

  localparam logic [WINDOW_LOG2-1:0] LAST_CNT = {WINDOW_LOG2{1'b1}};

  logic [ACC_WIDTH-1:0]             acc_q [NUM_STREAMS];
  logic [ACC_WIDTH-1:0]             acc_d [NUM_STREAMS];
  logic [ACC_WIDTH-1:0]             sum_v [NUM_STREAMS];
  logic [WINDOW_LOG2-1:0]           win_count_q, win_count_d;
  logic                             out_valid_q, out_valid_d;
  logic [NUM_STREAMS*ACC_WIDTH-1:0] out_data_q, out_data_d;
  logic                             at_last;
  logic                             accept;
  logic                             win_done;

  // Only the closing sample of a window can be held off, and only while the
  // previous word is still unconsumed.
  assign at_last   = (win_count_q == LAST_CNT);
  assign in_ready  = !(at_last && out_valid_q && !out_ready);
  assign accept    = in_valid && in_ready;
  assign win_done  = accept && at_last;

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign win_count = win_count_q;

  always_comb begin
    for (int i = 0; i < NUM_STREAMS; i++) begin
      sum_v[i] = acc_q[i] + ACC_WIDTH'(x_p[i]) - ACC_WIDTH'(x_m[i]);
    end
  end

  always_comb begin
    acc_d       = acc_q;
    win_count_d = win_count_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    if (accept) begin
      win_count_d = win_count_q + WINDOW_LOG2'(1);
      for (int i = 0; i < NUM_STREAMS; i++) begin
        acc_d[i] = sum_v[i];
      end
    end

    if (win_done) begin
      out_valid_d = 1'b1;
      for (int i = 0; i < NUM_STREAMS; i++) begin
        out_data_d[i*ACC_WIDTH +: ACC_WIDTH] = sum_v[i];
        acc_d[i] = '0;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < NUM_STREAMS; i++) begin
        acc_q[i] <= '0;
      end
      win_count_q <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      for (int i = 0; i < NUM_STREAMS; i++) begin
        acc_q[i] <= acc_d[i];
      end
      win_count_q <= win_count_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

endmodule

// File: tb/tb_stoch_signed_stream_decoder.sv
// Scoreboard bench for stoch_signed_stream_decoder: a window-sum model queues expected
// words; a monitor pops them on each output handshake.
module tb_stoch_signed_stream_decoder;

  localparam int N   = 16;
  localparam int W   = 8;
  localparam int AW  = W + 2;
  localparam int WIN = 1 << W;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [N-1:0]      x_p;
  logic [N-1:0]      x_m;
  logic              out_valid;
  logic              out_ready;
  logic [N*AW-1:0]   out_data;
  logic [W-1:0]      win_count;

  int checks = 0;
  int errors = 0;

  logic [N*AW-1:0] exp_q [$];
  int              sums [N];
  int              cnt;
  bit              pend;

  logic [N*AW-1:0] held_data;
  bit              held;

  always #5 clk = ~clk;

  stoch_signed_stream_decoder #(.NUM_STREAMS(N), .WINDOW_LOG2(W)) dut (
    .CLK       (clk),
    .RST       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x_p       (x_p),
    .x_m       (x_m),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .win_count (win_count)
  );

  task automatic chk(input string nm, input logic [N*AW-1:0] act, input logic [N*AW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: window sums of accepted samples; state reflects the DUT after each edge.
  always @(negedge clk) begin
    bit              exp_ready;
    logic [N*AW-1:0] word;
    bit              done;
    if (rst) begin
      foreach (sums[i]) sums[i] = 0;
      cnt  = 0;
      pend = 0;
      exp_q.delete();
    end else begin
      exp_ready = !(cnt == WIN - 1 && pend && !out_ready);
      chk("in_ready", N*AW'(in_ready), N*AW'(exp_ready));
      chk("out_valid", N*AW'(out_valid), N*AW'(pend));
      chk("win_count", N*AW'(win_count), N*AW'(cnt));
      done = 0;
      if (in_valid && exp_ready) begin
        foreach (sums[i]) sums[i] += int'(x_p[i]) - int'(x_m[i]);
        cnt++;
        if (cnt == WIN) begin
          foreach (sums[i]) word[i*AW +: AW] = AW'(sums[i]);
          exp_q.push_back(word);
          foreach (sums[i]) sums[i] = 0;
          cnt  = 0;
          done = 1;
        end
      end
      if (done) pend = 1;
      else if (pend && out_ready) pend = 0;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      held = 0;
    end else begin
      if (held && out_valid) chk("out_data_stable", out_data, held_data);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: got %h expected no word at %0t", out_data, $time);
        end else begin
          chk("out_data", out_data, exp_q.pop_front());
        end
      end
      held      = out_valid && !out_ready;
      held_data = out_data;
    end
  end

  task automatic run(input int n, input int valid_pct, input int ready_pct);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      in_valid  = ($urandom_range(99) < valid_pct);
      out_ready = ($urandom_range(99) < ready_pct);
      x_p       = N'($urandom);
      x_m       = N'($urandom);
    end
  endtask

  task automatic check_reset_state(input string nm);
    @(negedge clk);
    chk({nm, "_out_valid"}, N*AW'(out_valid), '0);
    chk({nm, "_out_data"}, out_data, '0);
    chk({nm, "_win_count"}, N*AW'(win_count), '0);
    chk({nm, "_in_ready"}, N*AW'(in_ready), N*AW'(1));
  endtask

  initial begin
    logic [N*AW-1:0] all_plus;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; x_p = '0; x_m = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_reset_state("reset");

    // Constant +1 on every lane
    for (int i = 0; i < N; i++) all_plus[i*AW +: AW] = AW'(WIN);
    for (int k = 0; k < WIN; k++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; out_ready = 1'b1; x_p = '1; x_m = '0;
    end
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    chk("const_valid", N*AW'(out_valid), N*AW'(1));
    chk("const_data", out_data, all_plus);
    @(negedge clk);
    chk("const_pulse_once", N*AW'(out_valid), '0);

    // Mixed lanes: +1, -1, cancel, alternating; upper lanes random
    for (int k = 0; k < WIN; k++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; out_ready = 1'b1;
      x_p = N'($urandom); x_m = N'($urandom);
      x_p[0] = 1'b1;   x_m[0] = 1'b0;
      x_p[1] = 1'b0;   x_m[1] = 1'b1;
      x_p[2] = 1'b1;   x_m[2] = 1'b1;
      x_p[3] = k[0];   x_m[3] = 1'b0;
    end
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    chk("mixed_valid", N*AW'(out_valid), N*AW'(1));
    chk("mixed_lane0", N*AW'(out_data[0*AW +: AW]), N*AW'(10'h100));
    chk("mixed_lane1", N*AW'(out_data[1*AW +: AW]), N*AW'(10'h300));
    chk("mixed_lane2", N*AW'(out_data[2*AW +: AW]), '0);
    chk("mixed_lane3", N*AW'(out_data[3*AW +: AW]), N*AW'(10'h080));

    // Backpressure: consumer stalled until the closing sample of window 2 is held
    for (int k = 0; k < 2 * WIN + 8; k++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; out_ready = 1'b0; x_p = N'($urandom); x_m = N'($urandom);
    end
    @(negedge clk);
    chk("stall_in_ready", N*AW'(in_ready), '0);
    chk("stall_win_count", N*AW'(win_count), N*AW'(WIN - 1));
    @(posedge clk); #1 out_ready = 1'b1;
    @(negedge clk);
    chk("handshake_in_ready", N*AW'(in_ready), N*AW'(1));
    @(posedge clk); #1 out_ready = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("no_bubble_valid", N*AW'(out_valid), N*AW'(1));
    run(4, 0, 100);

    // Random gaps and random consumer readiness
    run(900, 65, 50);
    run(700, 60, 100);

    // Reset mid-window with a pending word
    run(WIN + 20, 100, 100);
    for (int k = 0; k < 2 * WIN; k++) begin
      @(posedge clk); #1;
      out_ready = 1'b0; in_valid = 1'b1; x_p = N'($urandom); x_m = N'($urandom);
      if (out_valid && win_count == W'(100)) break;
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_win_count", N*AW'(win_count), N*AW'(100));
    chk("pre_rst_valid", N*AW'(out_valid), N*AW'(1));
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    check_reset_state("mid_rst");
    run(WIN + 10, 100, 100);
    run(300, 70, 80);

    run(20, 0, 100);
    @(negedge clk);
    chk("queue_drained", N*AW'(exp_q.size()), '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
